battle_fsm: RTL and testbench
=============================

# battle_fsm

Top-level battle phase controller for the bullet-dodging game. It sequences menu, player-attack and enemy-attack phases, and drives the 4-bit `state` and `turn` buses consumed by the enemy attack block. It counts the damage pulses and finished pulses that block returns, and keeps player and enemy HP. It declares WIN/LOSE and sits directly upstream of the enemy attack block and the HUD renderer.

## Interface
Parameters:
- `PLAYER_HP_INIT`, 20: player HP loaded on reset and on game start.
- `ENEMY_HP_INIT`, 30: enemy HP loaded on reset and on game start.
- `DAMAGE_PER_HIT`, 3: player HP lost per accepted damage pulse.
- `NUM_PATTERNS`, 4: turn counter modulus, range 1..16.
- `INVULN_CYCLES`, 32500000: damage-ignore window (0.5 s at 65 MHz). Used only with `BATTLE_INVULN_EN`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high. Clock is `clk`.
- `start_in`, in, 1: one-cycle pulse that starts a game, or restarts it from WIN/LOSE.
- `select_in`, in, 1: one-cycle pulse for the menu "FIGHT" confirm.
- `attack_done_in`, in, 1: one-cycle pulse marking the end of the player attack minigame.
- `attack_dmg_in`, in, 6: enemy damage, sampled when `attack_done_in` is high.
- `enemy_finished_in`, in, 1: one-cycle pulse when the enemy attack phase ends.
- `damage_in`, in, 1: one-cycle pulse when an arrow hits the player.
- `state_out`, out, 4: current phase encoding.
- `turn_out`, out, 4: pattern index for the enemy block.
- `player_hp_out`, out, 8: current player HP.
- `enemy_hp_out`, out, 8: current enemy HP.
- `invuln_out`, out, 1: high while the invulnerability window is active. Tied 0 when `BATTLE_INVULN_EN` is undefined.

## Operation
States and encodings:
- IDLE = 4'b0000
- MENU = 4'b0001
- PLAYER_ATK = 4'b0100
- ENEMY_ATK = 4'b1000
- WIN = 4'b1100
- LOSE = 4'b1110

Transitions:
- IDLE: on `start_in`, load both HP values from their INIT parameters, set `turn_out` to 0, go to MENU.
- MENU: on `select_in`, go to PLAYER_ATK. Other inputs are ignored.
- PLAYER_ATK: on `attack_done_in`, compute `enemy_hp - attack_dmg_in`, saturating at 0.
  - Result 0: go to WIN.
  - Otherwise: go to ENEMY_ATK.
- ENEMY_ATK: on `enemy_finished_in`, advance `turn_out` to `(turn_out+1) mod NUM_PATTERNS` and go to MENU.
- Damage, accepted only in ENEMY_ATK: `player_hp` drops by `DAMAGE_PER_HIT`, saturating at 0. If the result is 0, go to LOSE; this overrides any other transition in the same cycle.
- WIN/LOSE: hold all outputs. On `start_in`, reinitialise exactly as from IDLE and go to MENU.
- `damage_in` outside ENEMY_ATK is ignored.
- `attack_done_in` outside PLAYER_ATK is ignored.
- `enemy_finished_in` outside ENEMY_ATK is ignored.

Simultaneous events:
- `damage_in` and `enemy_finished_in` in the same cycle: apply the damage first.
  - HP reaches 0: go to LOSE, and `turn_out` is not advanced.
  - Otherwise: advance the turn and go to MENU.
- `start_in` in any non-IDLE/WIN/LOSE state: ignored.

Arithmetic:
- Subtractions use a 9-bit intermediate. Clamp to 0 on borrow.

## Timing
- All outputs are registered.
- Reset values:
  - `state_out` = IDLE
  - `turn_out` = 0
  - `player_hp_out` = `PLAYER_HP_INIT`
  - `enemy_hp_out` = `ENEMY_HP_INIT`
  - `invuln_out` = 0
  - invuln counter = 0
- Latency: an input pulse in cycle N is reflected in `state_out` and the HP outputs in cycle N+1.
- A new ENEMY_ATK entry always produces a state change, so the downstream block sees an edge into 4'b1000. MENU always sits between two consecutive ENEMY_ATK phases.
- Reset asserted mid-phase: all state returns to reset values on the next edge. No pending pulse is remembered.

## Configuration
- Macro: `BATTLE_INVULN_EN`.
- Defined:
  - An accepted damage pulse loads the counter with `INVULN_CYCLES-1` and sets `invuln_out`.
  - While the counter is nonzero, `damage_in` is ignored. The counter decrements every cycle.
  - `invuln_out` falls in the cycle after the counter reaches 0.
  - The counter clears on leaving ENEMY_ATK.
- Undefined: every `damage_in` in ENEMY_ATK is accepted, and `invuln_out` = 0.

## Structure
- `battle_pkg` holds:
  - the `battle_state_t` enum, with the encodings above;
  - `HP_W` = 8 and `TURN_W` = 4.
- The enemy block and the HUD both import `battle_pkg`.
- Sub-module `hp_counter`: a saturating down-counter with load, subtract amount, zero flag, and the optional invulnerability timer. Two instances: player and enemy. The enemy instance has the timer disabled through a parameter.

## Test plan
- Reset, then `start_in`, then `select_in` → `state_out` goes 0000 → 0001 → 0100, each change one cycle after its pulse.
- PLAYER_ATK with `attack_done_in` and `attack_dmg_in`=10 → `enemy_hp_out`=20, `state_out`=1000. Then `enemy_finished_in` → `turn_out`=1, `state_out`=0001.
- Seven `damage_in` pulses in ENEMY_ATK, macro undefined → HP goes 20 → 2 after six pulses. The seventh gives HP 0 and `state_out`=1110.
- `damage_in` and `enemy_finished_in` in the same cycle with HP=3 → HP 0, LOSE, `turn_out` unchanged.
- With `BATTLE_INVULN_EN` and `INVULN_CYCLES`=8: two damage pulses 4 cycles apart → only one decrement. A pulse 9 cycles after the first → second decrement.
- `NUM_PATTERNS`=4: four full turns → `turn_out` wraps 3 → 0. `rst` asserted mid ENEMY_ATK → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared types and widths for the battle controller, enemy attack block and HUD.
// Holds the phase encoding consumed downstream and a saturating subtract helper.
package battle_pkg;

    localparam int HP_W   = 8;
    localparam int TURN_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0000,
        ST_MENU       = 4'b0001,
        ST_PLAYER_ATK = 4'b0100,
        ST_ENEMY_ATK  = 4'b1000,
        ST_WIN        = 4'b1100,
        ST_LOSE       = 4'b1110
    } battle_state_t;

    // One extra bit catches the borrow; any borrow clamps the result to zero.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        logic [HP_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[HP_W] ? '0 : diff[HP_W-1:0];
    endfunction

endpackage

// File: rtl/battle_fsm_if.sv
// Event pulses into and phase/HP status out of the battle controller.
// The slave modport is the controller; the master modport is whoever drives the game events.
interface battle_fsm_if;
    import battle_pkg::*;

    logic              start_in;
    logic              select_in;
    logic              attack_done_in;
    logic [5:0]        attack_dmg_in;
    logic              enemy_finished_in;
    logic              damage_in;
    logic [3:0]        state_out;
    logic [TURN_W-1:0] turn_out;
    logic [HP_W-1:0]   player_hp_out;
    logic [HP_W-1:0]   enemy_hp_out;
    logic              invuln_out;

    modport master (
        output start_in, select_in, attack_done_in, attack_dmg_in,
               enemy_finished_in, damage_in,
        input  state_out, turn_out, player_hp_out, enemy_hp_out, invuln_out
    );

    modport slave (
        input  start_in, select_in, attack_done_in, attack_dmg_in,
               enemy_finished_in, damage_in,
        output state_out, turn_out, player_hp_out, enemy_hp_out, invuln_out
    );

endinterface

// File: rtl/battle_fsm_hp_counter.sv
// hp_counter: saturating HP down-counter with reload, zero-hit flag and an optional
// invulnerability timer that blocks further hits for TIMER_CYCLES cycles after one lands.
module hp_counter
    import battle_pkg::*;
#(
    parameter logic [HP_W-1:0] INIT         = 8'd20,
    parameter bit              TIMER_EN     = 1'b0,
    parameter int              TIMER_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            sub_req,
    input  logic [HP_W-1:0] sub_amt,
    input  logic            timer_clear,
    output logic [HP_W-1:0] value,
    output logic            hit_zero,
    output logic            invuln
);

    logic            blocked;
    logic            accept;
    logic [HP_W-1:0] sub_result;

    assign sub_result = sat_sub(value, sub_amt);
    assign accept     = sub_req && !blocked;
    assign hit_zero   = accept && (sub_result == '0);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= INIT;
        end else if (accept) begin
            value <= sub_result;
        end
    end

    generate
        if (TIMER_EN) begin : g_timer
            localparam int TW = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
            localparam logic [TW-1:0] RELOAD = TW'(TIMER_CYCLES - 1);

            logic [TW-1:0] count;

            assign blocked = (count != '0);

            // Clearing beats a same-cycle hit: leaving the phase always drops the window.
            always_ff @(posedge clk) begin
                if (rst || timer_clear) begin
                    count  <= '0;
                    invuln <= 1'b0;
                end else if (accept) begin
                    count  <= RELOAD;
                    invuln <= 1'b1;
                end else begin
                    count  <= blocked ? count - TW'(1) : count;
                    invuln <= blocked;
                end
            end
        end else begin : g_no_timer
            logic unused_timer;
            assign unused_timer = timer_clear;
            assign blocked      = 1'b0;
            assign invuln       = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/battle_fsm.sv
// battle_fsm: battle phase sequencer (menu / player attack / enemy attack / win / lose).
// Optional feature macro BATTLE_INVULN_EN enables the player invulnerability window.
module battle_fsm
    import battle_pkg::*;
#(
    parameter int PLAYER_HP_INIT = 20,
    parameter int ENEMY_HP_INIT  = 30,
    parameter int DAMAGE_PER_HIT = 3,
    parameter int NUM_PATTERNS   = 4,
    parameter int INVULN_CYCLES  = 32500000
) (
    input logic          clk,
    input logic          rst,
    battle_fsm_if.slave  bus
);

`ifdef BATTLE_INVULN_EN
    localparam bit PLAYER_TIMER_EN = 1'b1;
`else
    localparam bit PLAYER_TIMER_EN = 1'b0;
`endif

    localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(NUM_PATTERNS - 1);

    battle_state_t     state_r;
    logic [TURN_W-1:0] turn_r;
    logic [TURN_W-1:0] turn_next;

    logic start_ok;
    logic player_sub;
    logic enemy_sub;
    logic player_zero;
    logic enemy_zero;
    logic player_timer_clear;
    logic enemy_invuln_unused;

    assign start_ok   = bus.start_in && (state_r inside {ST_IDLE, ST_WIN, ST_LOSE});
    assign player_sub = bus.damage_in && (state_r == ST_ENEMY_ATK);
    assign enemy_sub  = bus.attack_done_in && (state_r == ST_PLAYER_ATK);
    assign turn_next  = (turn_r == LAST_TURN) ? '0 : turn_r + TURN_W'(1);

    // The window only runs inside ENEMY_ATK and is dropped on the way out.
    assign player_timer_clear = (state_r != ST_ENEMY_ATK) || player_zero || bus.enemy_finished_in;

    hp_counter #(
        .INIT         (HP_W'(PLAYER_HP_INIT)),
        .TIMER_EN     (PLAYER_TIMER_EN),
        .TIMER_CYCLES (INVULN_CYCLES)
    ) u_player_hp (
        .clk         (clk),
        .rst         (rst),
        .load        (start_ok),
        .sub_req     (player_sub),
        .sub_amt     (HP_W'(DAMAGE_PER_HIT)),
        .timer_clear (player_timer_clear),
        .value       (bus.player_hp_out),
        .hit_zero    (player_zero),
        .invuln      (bus.invuln_out)
    );

    hp_counter #(
        .INIT         (HP_W'(ENEMY_HP_INIT)),
        .TIMER_EN     (1'b0),
        .TIMER_CYCLES (1)
    ) u_enemy_hp (
        .clk         (clk),
        .rst         (rst),
        .load        (start_ok),
        .sub_req     (enemy_sub),
        .sub_amt     (HP_W'(bus.attack_dmg_in)),
        .timer_clear (1'b1),
        .value       (bus.enemy_hp_out),
        .hit_zero    (enemy_zero),
        .invuln      (enemy_invuln_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            turn_r  <= '0;
        end else begin
            unique case (state_r)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (bus.start_in) begin
                        state_r <= ST_MENU;
                        turn_r  <= '0;
                    end
                end
                ST_MENU: begin
                    if (bus.select_in) state_r <= ST_PLAYER_ATK;
                end
                ST_PLAYER_ATK: begin
                    if (bus.attack_done_in) state_r <= enemy_zero ? ST_WIN : ST_ENEMY_ATK;
                end
                ST_ENEMY_ATK: begin
                    // A lethal hit wins over a same-cycle finish and freezes the turn.
                    if (player_zero) begin
                        state_r <= ST_LOSE;
                    end else if (bus.enemy_finished_in) begin
                        state_r <= ST_MENU;
                        turn_r  <= turn_next;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.state_out = state_r;
    assign bus.turn_out  = turn_r;

endmodule

// File: tb/tb_battle_fsm.sv
// Self-checking bench for battle_fsm: directed scenarios followed by random event
// pulses, every cycle compared against an event-level model of the game rules.
module tb_battle_fsm;

    localparam int P_INIT  = 20;
    localparam int E_INIT  = 30;
    localparam int DMG_HIT = 3;
    localparam int NPAT    = 4;
    localparam int INV_CYC = 8;

`ifdef BATTLE_INVULN_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    battle_fsm_if bus ();

    battle_fsm #(
        .PLAYER_HP_INIT (P_INIT),
        .ENEMY_HP_INIT  (E_INIT),
        .DAMAGE_PER_HIT (DMG_HIT),
        .NUM_PATTERNS   (NPAT),
        .INVULN_CYCLES  (INV_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {PH_IDLE, PH_MENU, PH_PATK, PH_EATK, PH_WIN, PH_LOSE} phase_e;

    phase_e ph = PH_IDLE;
    int m_php = P_INIT;
    int m_ehp = E_INIT;
    int m_turn = 0;
    int m_edge = 0;
    int m_last_hit = -1000000;

    int checks = 0;
    int failures = 0;

    function automatic logic [3:0] phase_code(input phase_e p);
        case (p)
            PH_MENU: return 4'b0001;
            PH_PATK: return 4'b0100;
            PH_EATK: return 4'b1000;
            PH_WIN:  return 4'b1100;
            PH_LOSE: return 4'b1110;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit sel, input bit done,
                              input logic [5:0] dmg, input bit fin, input bit hit);
        bit took;
        m_edge++;
        took = 1'b0;
        if (r) begin
            ph = PH_IDLE; m_php = P_INIT; m_ehp = E_INIT; m_turn = 0;
        end else begin
            case (ph)
                PH_IDLE, PH_WIN, PH_LOSE:
                    if (s) begin
                        ph = PH_MENU; m_php = P_INIT; m_ehp = E_INIT; m_turn = 0;
                    end
                PH_MENU:
                    if (sel) ph = PH_PATK;
                PH_PATK:
                    if (done) begin
                        m_ehp = (m_ehp > int'(dmg)) ? m_ehp - int'(dmg) : 0;
                        ph = (m_ehp == 0) ? PH_WIN : PH_EATK;
                    end
                PH_EATK: begin
                    took = hit && (!INV_ON || (m_edge - m_last_hit >= INV_CYC));
                    if (took) begin
                        m_php = (m_php > DMG_HIT) ? m_php - DMG_HIT : 0;
                        m_last_hit = m_edge;
                    end
                    if (took && m_php == 0) begin
                        ph = PH_LOSE;
                    end else if (fin) begin
                        m_turn = (m_turn + 1) % NPAT;
                        ph = PH_MENU;
                    end
                end
                default: ;
            endcase
        end
        if (ph != PH_EATK) m_last_hit = -1000000;
    endtask

    task automatic compare_all();
        logic exp_inv;
        exp_inv = INV_ON && (ph == PH_EATK) && (m_edge - m_last_hit < INV_CYC);
        check("state", 32'(bus.state_out), 32'(phase_code(ph)));
        check("turn", 32'(bus.turn_out), 32'(m_turn));
        check("player_hp", 32'(bus.player_hp_out), 32'(m_php));
        check("enemy_hp", 32'(bus.enemy_hp_out), 32'(m_ehp));
        check("invuln", 32'(bus.invuln_out), 32'(exp_inv));
    endtask

    task automatic tick(input bit r, input bit s, input bit sel, input bit done,
                        input logic [5:0] dmg, input bit fin, input bit hit);
        @(negedge clk);
        rst                   = r;
        bus.start_in          = s;
        bus.select_in         = sel;
        bus.attack_done_in    = done;
        bus.attack_dmg_in     = dmg;
        bus.enemy_finished_in = fin;
        bus.damage_in         = hit;
        @(posedge clk);
        model_step(r, s, sel, done, dmg, fin, hit);
        #1 compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 6'd0, 0, 0);
    endtask

    task automatic do_start();          tick(0, 1, 0, 0, 6'd0, 0, 0); endtask
    task automatic do_select();         tick(0, 0, 1, 0, 6'd0, 0, 0); endtask
    task automatic do_done(input logic [5:0] d); tick(0, 0, 0, 1, d, 0, 0); endtask
    task automatic do_fin();            tick(0, 0, 0, 0, 6'd0, 1, 0); endtask
    task automatic do_hit();            tick(0, 0, 0, 0, 6'd0, 0, 1); endtask

    initial begin
        bus.start_in = 0; bus.select_in = 0; bus.attack_done_in = 0;
        bus.attack_dmg_in = '0; bus.enemy_finished_in = 0; bus.damage_in = 0;

        tick(1, 0, 0, 0, 6'd0, 0, 0);
        tick(1, 0, 0, 0, 6'd0, 0, 0);
        check("rst_state", 32'(bus.state_out), 32'h0);
        check("rst_turn", 32'(bus.turn_out), 0);
        check("rst_php", 32'(bus.player_hp_out), 20);
        check("rst_ehp", 32'(bus.enemy_hp_out), 30);
        check("rst_inv", 32'(bus.invuln_out), 0);

        // start / select / attack / finish walk-through
        do_start();  check("start_menu", 32'(bus.state_out), 32'h1);
        do_select(); check("select_patk", 32'(bus.state_out), 32'h4);
        do_done(6'd10);
        check("atk_ehp", 32'(bus.enemy_hp_out), 20);
        check("atk_state", 32'(bus.state_out), 32'h8);
        do_fin();
        check("fin_turn", 32'(bus.turn_out), 1);
        check("fin_state", 32'(bus.state_out), 32'h1);

        // seven spaced hits take the player from 20 to 0
        do_select(); do_done(6'd1);
        for (int i = 0; i < 6; i++) begin
            do_hit(); idle(9);
        end
        check("six_hits_php", 32'(bus.player_hp_out), 2);
        do_hit();
        check("lethal_php", 32'(bus.player_hp_out), 0);
        check("lethal_state", 32'(bus.state_out), 32'he);

        // restart, then lethal hit coinciding with finish
        do_start();
        check("restart_php", 32'(bus.player_hp_out), 20);
        check("restart_state", 32'(bus.state_out), 32'h1);
        do_select(); do_done(6'd1);
        for (int i = 0; i < 6; i++) begin
            do_hit(); idle(9);
        end
        tick(0, 0, 0, 0, 6'd0, 1, 1);
        check("simul_php", 32'(bus.player_hp_out), 0);
        check("simul_state", 32'(bus.state_out), 32'he);
        check("simul_turn", 32'(bus.turn_out), 0);

        // non-lethal hit with finish advances the turn
        do_start(); do_select(); do_done(6'd1);
        tick(0, 0, 0, 0, 6'd0, 1, 1);
        check("nonlethal_php", 32'(bus.player_hp_out), 17);
        check("nonlethal_state", 32'(bus.state_out), 32'h1);
        check("nonlethal_turn", 32'(bus.turn_out), 1);

        // turn wrap 3 -> 0
        for (int i = 0; i < 3; i++) begin
            do_select(); do_done(6'd1); do_fin();
            if (i == 1) check("turn_three", 32'(bus.turn_out), 3);
        end
        check("turn_wrap", 32'(bus.turn_out), 0);

        // hits 4 and 9 cycles after a first hit
        do_select(); do_done(6'd1);
        do_hit(); idle(3); do_hit(); idle(4); do_hit();
        check("inv_php", 32'(bus.player_hp_out), INV_ON ? 11 : 8);

        // reset in the middle of ENEMY_ATK
        tick(1, 0, 0, 0, 6'd0, 0, 1);
        check("midrst_state", 32'(bus.state_out), 32'h0);
        check("midrst_turn", 32'(bus.turn_out), 0);
        check("midrst_php", 32'(bus.player_hp_out), 20);
        check("midrst_ehp", 32'(bus.enemy_hp_out), 30);
        check("midrst_inv", 32'(bus.invuln_out), 0);

        // random event soup
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 299) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 6'($urandom_range(0, 40)),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
